wb_retire_checker: RTL

- Synthesisable in-order retire checker for the pipeline core.
- A bench or self-test harness preloads expected (rd, data) writebacks into an internal FIFO. The block then compares them against the core's writeback stream (register index plus write data), one retire per cycle.
- Generalises a fixed per-cycle scoreboard check to a parametrised width/depth, stall-tolerant checker with pass/fail counters, first-failure capture and a hang timeout.

---
 rtl/wb_retire_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_retire_checker.sv
// In-order writeback retire checker: compares the core's writeback stream against
// a preloaded FIFO of expected (rd, data) entries, with counters, first-failure capture and hang timeout.
module wb_retire_checker #(
   parameter int XLEN      = 32,
   parameter int RW        = 5,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 64,
   parameter bit IGNORE_X0 = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [RW-1:0]    exp_rd,
   input  logic [XLEN-1:0]  exp_data,
   input  logic             exp_last,
   input  logic             wb_valid,
   input  logic [RW-1:0]    wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             busy,
   output logic             done,
   output logic             pass_o,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             timeout,
   output logic             unexpected,
   output logic             ff_valid,
   output logic [CNT_W-1:0] ff_index,
   output logic [RW-1:0]    ff_rd,
   output logic [XLEN-1:0]  ff_data,
   output logic [1:0]       dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: an expected entry transfers on a cycle where exp_valid && exp_ready
   // and the checker is not in DONE; exp_ready depends only on FIFO fullness.

   state_t           state;
   logic [RW-1:0]    mem_rd   [DEPTH];
   logic [XLEN-1:0]  mem_data [DEPTH];
   logic             mem_last [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             last_seen;
   logic [TW-1:0]    idle_cnt;

   logic             full;
   logic             empty;
   logic             push;
   logic             retire;
   logic             pop;
   logic             match;
   logic             fail_ev;
   logic [RW-1:0]    head_rd;
   logic [XLEN-1:0]  head_data;
   logic             head_last;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign exp_ready = !full;
   assign push      = exp_valid && !full && (state != DONE);

   assign retire    = (state == RUN) && wb_valid && !(IGNORE_X0 && (wb_rd == '0));
   assign pop       = retire && !empty;
   assign head_rd   = mem_rd[rd_ptr[AW-1:0]];
   assign head_data = mem_data[rd_ptr[AW-1:0]];
   assign head_last = mem_last[rd_ptr[AW-1:0]];
   // Compare against the registered head only; a same-cycle push is never bypassed.
   assign match     = pop && (wb_rd == head_rd) && (wb_data == head_data);
   assign fail_ev   = retire && !match;

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign pass_o    = done && (fail_count == '0) && !timeout && !unexpected;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr[AW-1:0]]   <= exp_rd;
         mem_data[wr_ptr[AW-1:0]] <= exp_data;
         mem_last[wr_ptr[AW-1:0]] <= exp_last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         last_seen  <= 1'b0;
         idle_cnt   <= '0;
         pass_count <= '0;
         fail_count <= '0;
         timeout    <= 1'b0;
         unexpected <= 1'b0;
         ff_valid   <= 1'b0;
         ff_index   <= '0;
         ff_rd      <= '0;
         ff_data    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  last_seen  <= 1'b0;
                  idle_cnt   <= '0;
                  pass_count <= '0;
                  fail_count <= '0;
                  timeout    <= 1'b0;
                  unexpected <= 1'b0;
                  ff_valid   <= 1'b0;
                  ff_index   <= '0;
                  ff_rd      <= '0;
                  ff_data    <= '0;
               end
            end
            RUN: begin
               if (match) begin
                  if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
               end else if (retire) begin
                  if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
               end
               if (fail_ev && !ff_valid) begin
                  ff_valid <= 1'b1;
                  ff_index <= pass_count + fail_count;
                  ff_rd    <= wb_rd;
                  ff_data  <= wb_data;
               end
               if (retire && empty)    unexpected <= 1'b1;
               if (pop && head_last)   last_seen  <= 1'b1;
               // Hang watchdog counts only cycles where work is pending but nothing retires.
               if (retire || empty) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                  idle_cnt <= idle_cnt + TW'(1);
                  timeout  <= 1'b1;
                  state    <= DONE;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
               if (last_seen && empty) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
